// File: rtl/julia_mem_ctrl.sv
// Write-bus arbiter for the julia_worker array: round-robin grant, one bus write per
// request, per-lane done/busy handshakes and an end-of-frame pulse.
module julia_mem_ctrl #(
  parameter int unsigned NUM_WORKERS = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_PIXELS  = 307200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_WORKERS-1:0]        jw_done,
  input  logic [NUM_WORKERS*DATA_W-1:0] color_in,
  input  logic [NUM_WORKERS*ADDR_W-1:0] addr_in,
  input  logic                          wr_done,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [NUM_WORKERS-1:0]        mc_done,
  output logic [NUM_WORKERS-1:0]        mc_busy,
  output logic                          frame_done
);

  localparam int unsigned GW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int unsigned CW = $clog2(NUM_PIXELS + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACK = 2'd1;
  localparam logic [1:0] S_RELEASE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   wr_ready_q, wr_ready_d;
  logic [NUM_WORKERS-1:0] mc_done_q, mc_done_d;
  logic                   frame_done_q, frame_done_d;

  logic                   pick_vld;
  logic [GW-1:0]          pick_idx;
  logic [GW-1:0]          lane_idx;
  logic [NUM_WORKERS-1:0] grant_oh;

  // First requesting lane at or after rr_ptr, wrapping around the lane count.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    lane_idx = '0;
    for (int unsigned k = 0; k < NUM_WORKERS; k++) begin
      lane_idx = GW'((32'(rr_ptr_q) + k) % NUM_WORKERS);
      if (!pick_vld && jw_done[lane_idx]) begin
        pick_vld = 1'b1;
        pick_idx = lane_idx;
      end
    end
  end

  assign grant_oh = {{(NUM_WORKERS-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    pix_cnt_d    = pix_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_ready_d   = wr_ready_q;
    mc_done_d    = '0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_idx;
          wr_addr_d  = addr_in[pick_idx*ADDR_W +: ADDR_W];
          wr_data_d  = color_in[pick_idx*DATA_W +: DATA_W];
          wr_ready_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (wr_done) begin
          wr_ready_d = 1'b0;
          mc_done_d  = grant_oh;
          state_d    = S_RELEASE;
          if (pix_cnt_q == CW'(NUM_PIXELS - 1)) begin
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        // Wait for the served worker to lower its request so the pixel is not written twice.
        if (!jw_done[grant_q]) begin
          rr_ptr_d = (grant_q == GW'(NUM_WORKERS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame restart overrides any count update, including a write acknowledged this cycle.
    if (start) begin
      pix_cnt_d    = '0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      pix_cnt_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_ready_q   <= 1'b0;
      mc_done_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      pix_cnt_q    <= pix_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_ready_q   <= wr_ready_d;
      mc_done_q    <= mc_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    mc_busy = '0;
    if (state_q != S_IDLE) mc_busy = jw_done & ~grant_oh;
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_ready   = wr_ready_q;
  assign mc_done    = mc_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_julia_mem_ctrl.sv
// Bench for julia_mem_ctrl: directed scenarios plus randomized transactions against a
// transaction-level model (rotated-mask grant, integer pixel count).
module tb_julia_mem_ctrl;

  localparam int unsigned NW = 16;
  localparam int unsigned NP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NW-1:0]     req = '0;
  logic [NW*32-1:0]  color_in;
  logic [NW*32-1:0]  addr_in;
  logic              wr_done = 1'b0;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic [NW-1:0]     mc_done;
  logic [NW-1:0]     mc_busy;
  logic              frame_done;

  logic [31:0] col [NW];
  logic [31:0] adr [NW];

  int checks = 0;
  int failures = 0;
  int unsigned m_rr = 0;
  int unsigned m_cnt = 0;
  int unsigned last_g = 0;

  julia_mem_ctrl #(
    .NUM_WORKERS(NW),
    .DATA_W     (32),
    .ADDR_W     (32),
    .NUM_PIXELS (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .jw_done   (req),
    .color_in  (color_in),
    .addr_in   (addr_in),
    .wr_done   (wr_done),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mc_done   (mc_done),
    .mc_busy   (mc_busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    color_in = '0;
    addr_in  = '0;
    for (int i = 0; i < NW; i++) begin
      color_in[i*32 +: 32] = col[i];
      addr_in[i*32 +: 32]  = adr[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rotate the request mask so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic int unsigned model_pick(input logic [NW-1:0] m, input int unsigned p);
    logic [2*NW-1:0] d;
    logic [NW-1:0]   r, low;
    d   = {m, m};
    r   = NW'(d >> p);
    low = r & (~r + 1'b1);
    return (int'($clog2(low)) + p) % NW;
  endfunction

  // One full transaction from IDLE; req must be nonzero on entry.
  task automatic txn(input int unsigned waitc, input int unsigned holdc, input bit st_ack,
                     input bit keep_others, input bit scramble);
    int unsigned g;
    logic [31:0] ea, ed;
    logic [NW-1:0] g_oh;
    logic exp_fd;
    g    = model_pick(req, m_rr);
    g_oh = NW'(1) << g;
    ea   = adr[g];
    ed   = col[g];
    step();
    chk("wr_ready_rise", 64'(wr_ready), 64'(1));
    chk("wr_addr", 64'(wr_addr), 64'(ea));
    chk("wr_data", 64'(wr_data), 64'(ed));
    chk("mc_busy_wait", 64'(mc_busy), 64'(req & ~g_oh));
    for (int unsigned i = 0; i < waitc; i++) begin
      if (scramble) begin
        for (int j = 0; j < NW; j++) begin
          col[j] = $urandom;
          adr[j] = $urandom;
        end
        if ($urandom_range(0, 5) == 0) begin
          start = 1'b1;
          m_cnt = 0;
        end
      end
      step();
      start = 1'b0;
      chk("wr_ready_hold", 64'(wr_ready), 64'(1));
      chk("wr_addr_hold", 64'(wr_addr), 64'(ea));
      chk("wr_data_hold", 64'(wr_data), 64'(ed));
      chk("mc_done_wait", 64'(mc_done), 64'(0));
    end
    wr_done = 1'b1;
    start   = st_ack;
    step();
    wr_done = 1'b0;
    start   = 1'b0;
    exp_fd  = 1'b0;
    if (st_ack) m_cnt = 0;
    else begin
      m_cnt++;
      if (m_cnt == NP) begin
        exp_fd = 1'b1;
        m_cnt  = 0;
      end
    end
    chk("mc_done_pulse", 64'(mc_done), 64'(g_oh));
    chk("wr_ready_fall", 64'(wr_ready), 64'(0));
    chk("frame_done", 64'(frame_done), 64'(exp_fd));
    for (int unsigned i = 0; i < holdc; i++) begin
      wr_done = 1'($urandom_range(0, 1));
      step();
      wr_done = 1'b0;
      chk("mc_done_hold", 64'(mc_done), 64'(0));
      chk("wr_ready_hold_rel", 64'(wr_ready), 64'(0));
      chk("frame_done_hold", 64'(frame_done), 64'(0));
      chk("mc_busy_rel", 64'(mc_busy), 64'(req & ~g_oh));
    end
    if (keep_others) req = req & ~g_oh;
    else req = NW'($urandom) & ~g_oh;
    step();
    m_rr = (g + 1) % NW;
    chk("mc_busy_idle", 64'(mc_busy), 64'(0));
    chk("mc_done_idle", 64'(mc_done), 64'(0));
    chk("wr_ready_idle", 64'(wr_ready), 64'(0));
    last_g = g;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      col[i] = 32'hC000_0000 + 32'(i);
      adr[i] = 32'h0000_0100 * 32'(i) + 32'h10;
    end
    #2;
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_mc_done", 64'(mc_done), 64'(0));
    chk("rst_mc_busy", 64'(mc_busy), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    step();
    rst = 1'b0;
    step();

    // All lanes at once: served 0..15, remaining requesters stay asserted.
    req = '1;
    for (int i = 0; i < NW; i++) txn(0, 0, 1'b0, 1'b1, 1'b0);

    // Single request on lane 3 with a four-cycle acknowledge delay.
    col[3] = 32'hFF00_FF00;
    adr[3] = 32'h0000_1000;
    req    = NW'(1) << 3;
    txn(4, 0, 1'b0, 1'b1, 1'b0);

    // Wrap: serve lane 13 to leave rr_ptr at 14, then {0,1,15} -> 15,0,1.
    req = NW'(1) << 13;
    txn(0, 0, 1'b0, 1'b1, 1'b0);
    req = (NW'(1) << 15) | NW'(3);
    for (int i = 0; i < 3; i++) txn(1, 0, 1'b0, 1'b1, 1'b0);

    // Held request on lane 5 for three cycles after mc_done.
    req = NW'(1) << 5;
    txn(2, 3, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with random delays, holds, lane scrambling and restarts.
    for (int n = 0; n < 40; n++) begin
      while (req == '0) req = NW'($urandom);
      txn($urandom_range(0, 4), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
          1'b0, 1'b1);
    end

    // Restart coinciding with an acknowledge: the write is not counted.
    req = NW'(1) << 7;
    txn(1, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NP; i++) begin
      req = NW'(1) << 9;
      txn(0, 1, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset during WAIT_ACK.
    req = '1;
    step();
    chk("pre_rst_wr_ready", 64'(wr_ready), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_wr_ready", 64'(wr_ready), 64'(0));
    chk("arst_mc_busy", 64'(mc_busy), 64'(0));
    chk("arst_mc_done", 64'(mc_done), 64'(0));
    chk("arst_wr_addr", 64'(wr_addr), 64'(0));
    m_rr  = 0;
    m_cnt = 0;
    step();
    rst = 1'b0;
    txn(1, 0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_lane0_served", 64'(req[0]), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
